// File: rtl/vpu_sequencer.sv
// Instruction sequencer for the systolic VPU: fetches 32-bit words from the
// instruction memory and turns them into one-cycle array strobes and dp_ram reads.
module vpu_sequencer #(
    parameter int          DATA_WIDTH     = 8,
    parameter int          MATRIX_SIZE    = 8,
    parameter int          ACC_ADDR_WIDTH = $clog2(MATRIX_SIZE * MATRIX_SIZE),
    parameter int          DP_ADDR_WIDTH  = 10,
    parameter int unsigned TOP_OFFSET     = 'h40,
    parameter int          INSTR_DEPTH    = 256,
    parameter int          PC_WIDTH       = $clog2(INSTR_DEPTH),
    parameter int          LOOP_WIDTH     = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      step,
    input  logic                      run,
    input  logic                      halt,
    output logic [PC_WIDTH-1:0]       imem_addr,
    input  logic [31:0]               imem_data,
    output logic [DP_ADDR_WIDTH-1:0]  ram_addr_a,
    output logic [DP_ADDR_WIDTH-1:0]  ram_addr_b,
    input  logic [DATA_WIDTH-1:0]     ram_dout_a,
    input  logic [DATA_WIDTH-1:0]     ram_dout_b,
    output logic                      load_en_left,
    output logic                      load_en_top,
    output logic [DATA_WIDTH-1:0]     data_in_left,
    output logic [DATA_WIDTH-1:0]     data_in_top,
    output logic                      swap_left,
    output logic                      swap_top,
    output logic                      shift_right,
    output logic                      shift_down,
    output logic                      acc_en,
    output logic                      acc_rd_en,
    output logic [ACC_ADDR_WIDTH-1:0] addr_acc,
    output logic                      acc_rst,
    output logic                      buffer_rst,
    output logic [PC_WIDTH-1:0]       pc_out,
    output logic [31:0]               instr_out,
    output logic [2:0]                state_out,
    output logic                      running,
    output logic                      done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_EXEC    = 3'd2,
        S_LCOMMIT = 3'd3,
        S_WAIT    = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t                    state_q, state_d;
    logic [PC_WIDTH-1:0]       pc_q, pc_d;
    logic [LOOP_WIDTH-1:0]     loop_q, loop_d;
    logic [12:0]               wait_q, wait_d;
    logic [31:0]               instr_q, instr_d;
    logic                      running_q, running_d;
    logic                      done_q, done_d;
    logic                      ld_left_q, ld_left_d;
    logic                      ld_top_q, ld_top_d;
    logic [DATA_WIDTH-1:0]     din_left_q, din_left_d;
    logic [DATA_WIDTH-1:0]     din_top_q, din_top_d;
    logic                      swap_left_q, swap_left_d;
    logic                      swap_top_q, swap_top_d;
    logic                      shift_right_q, shift_right_d;
    logic                      shift_down_q, shift_down_d;
    logic                      acc_en_q, acc_en_d;
    logic                      acc_rd_q, acc_rd_d;
    logic [ACC_ADDR_WIDTH-1:0] addr_acc_q, addr_acc_d;
    logic                      clr_q, clr_d;
    logic [DP_ADDR_WIDTH-1:0]  raddr_a_q, raddr_a_d;
    logic [DP_ADDR_WIDTH-1:0]  raddr_b_q, raddr_b_d;

    // Decode of the word arriving on imem_data (meaningful only in EXEC)
    logic [12:0]              ex_addr;
    logic                     ex_imm, ex_loop, ex_setloop, ex_halt;
    logic                     ex_ram_a, ex_ram_b;
    logic [DP_ADDR_WIDTH-1:0] ex_addr_a, ex_addr_b;
    logic [PC_WIDTH-1:0]      pc_inc;
    logic                     boundary, bnd_halt;
    logic                     unused_bits;

    assign ex_addr    = imem_data[12:0];
    assign ex_imm     = imem_data[13];
    assign ex_loop    = imem_data[14];
    assign ex_setloop = imem_data[15];
    assign ex_halt    = imem_data[17];
    assign ex_ram_a   = imem_data[31] & ~ex_imm;
    assign ex_ram_b   = imem_data[30] & ~ex_imm;
    assign ex_addr_a  = DP_ADDR_WIDTH'(ex_addr);
    assign ex_addr_b  = (ex_ram_a & ex_ram_b) ? ex_addr_a + DP_ADDR_WIDTH'(TOP_OFFSET)
                                              : ex_addr_a;
    assign pc_inc     = (pc_q == PC_WIDTH'(INSTR_DEPTH - 1)) ? '0 : pc_q + PC_WIDTH'(1);
    assign unused_bits = ^{imem_data[19:16], instr_q};

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        loop_d        = loop_q;
        wait_d        = wait_q;
        instr_d       = instr_q;
        running_d     = running_q;
        done_d        = done_q;
        ld_left_d     = 1'b0;
        ld_top_d      = 1'b0;
        din_left_d    = din_left_q;
        din_top_d     = din_top_q;
        swap_left_d   = 1'b0;
        swap_top_d    = 1'b0;
        shift_right_d = 1'b0;
        shift_down_d  = 1'b0;
        acc_en_d      = 1'b0;
        acc_rd_d      = 1'b0;
        addr_acc_d    = addr_acc_q;
        clr_d         = 1'b0;
        raddr_a_d     = raddr_a_q;
        raddr_b_d     = raddr_b_q;
        boundary      = 1'b0;
        bnd_halt      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    running_d = 1'b1;
                    state_d   = S_FETCH;
                end else if (step) begin
                    running_d = 1'b0;
                    state_d   = S_FETCH;
                end
            end
            S_FETCH: state_d = S_EXEC;
            S_EXEC: begin
                instr_d       = imem_data;
                swap_left_d   = imem_data[29];
                swap_top_d    = imem_data[28];
                shift_right_d = imem_data[27];
                shift_down_d  = imem_data[26];
                acc_en_d      = imem_data[25];
                acc_rd_d      = imem_data[24];
                clr_d         = imem_data[21];
                if (imem_data[25] | imem_data[24])
                    addr_acc_d = ACC_ADDR_WIDTH'(ex_addr);
                if (ex_imm && imem_data[31]) begin
                    ld_left_d  = 1'b1;
                    din_left_d = DATA_WIDTH'(ex_addr);
                end
                if (ex_imm && imem_data[30]) begin
                    ld_top_d  = 1'b1;
                    din_top_d = DATA_WIDTH'(ex_addr);
                end
                if (ex_ram_a) raddr_a_d = ex_addr_a;
                if (ex_ram_b) raddr_b_d = ex_addr_b;

                // Loop test uses the counter value before this instruction; SET_LOOP wins the write
                if (imem_data[22] && !ex_loop) begin
                    pc_d = PC_WIDTH'(ex_addr);
                end else if (imem_data[22] && loop_q != '0) begin
                    loop_d = loop_q - LOOP_WIDTH'(1);
                    pc_d   = PC_WIDTH'(ex_addr);
                end else begin
                    pc_d = pc_inc;
                end
                if (ex_setloop) loop_d = LOOP_WIDTH'(ex_addr);

                if (ex_ram_a | ex_ram_b) begin
                    state_d = S_LCOMMIT;
                end else if (imem_data[23] && ex_addr != '0) begin
                    wait_d  = ex_addr;
                    state_d = S_WAIT;
                end else begin
                    boundary = 1'b1;
                    bnd_halt = ex_halt;
                end
            end
            S_LCOMMIT: begin
                ld_left_d = instr_q[31];
                ld_top_d  = instr_q[30];
                if (instr_q[31]) din_left_d = ram_dout_a;
                if (instr_q[30]) din_top_d  = ram_dout_b;
                if (instr_q[23] && instr_q[12:0] != '0) begin
                    wait_d  = instr_q[12:0];
                    state_d = S_WAIT;
                end else begin
                    boundary = 1'b1;
                    bnd_halt = instr_q[17];
                end
            end
            S_WAIT: begin
                if (wait_q <= 13'd1) begin
                    boundary = 1'b1;
                    bnd_halt = instr_q[17];
                end else begin
                    wait_d = wait_q - 13'd1;
                end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase

        if (boundary) begin
            if (bnd_halt) begin
                state_d   = S_DONE;
                done_d    = 1'b1;
                running_d = 1'b0;
            end else if (running_q && !halt) begin
                state_d = S_FETCH;
            end else begin
                state_d   = S_IDLE;
                running_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pc_q          <= '0;
            loop_q        <= '0;
            wait_q        <= '0;
            instr_q       <= '0;
            running_q     <= 1'b0;
            done_q        <= 1'b0;
            ld_left_q     <= 1'b0;
            ld_top_q      <= 1'b0;
            din_left_q    <= '0;
            din_top_q     <= '0;
            swap_left_q   <= 1'b0;
            swap_top_q    <= 1'b0;
            shift_right_q <= 1'b0;
            shift_down_q  <= 1'b0;
            acc_en_q      <= 1'b0;
            acc_rd_q      <= 1'b0;
            addr_acc_q    <= '0;
            clr_q         <= 1'b0;
            raddr_a_q     <= '0;
            raddr_b_q     <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            loop_q        <= loop_d;
            wait_q        <= wait_d;
            instr_q       <= instr_d;
            running_q     <= running_d;
            done_q        <= done_d;
            ld_left_q     <= ld_left_d;
            ld_top_q      <= ld_top_d;
            din_left_q    <= din_left_d;
            din_top_q     <= din_top_d;
            swap_left_q   <= swap_left_d;
            swap_top_q    <= swap_top_d;
            shift_right_q <= shift_right_d;
            shift_down_q  <= shift_down_d;
            acc_en_q      <= acc_en_d;
            acc_rd_q      <= acc_rd_d;
            addr_acc_q    <= addr_acc_d;
            clr_q         <= clr_d;
            raddr_a_q     <= raddr_a_d;
            raddr_b_q     <= raddr_b_d;
        end
    end

    // Read address is presented during EXEC so dp_ram data lands in LOAD_COMMIT; the register holds it after
    assign ram_addr_a   = (state_q == S_EXEC && ex_ram_a) ? ex_addr_a : raddr_a_q;
    assign ram_addr_b   = (state_q == S_EXEC && ex_ram_b) ? ex_addr_b : raddr_b_q;
    assign imem_addr    = pc_q;
    assign load_en_left = ld_left_q;
    assign load_en_top  = ld_top_q;
    assign data_in_left = din_left_q;
    assign data_in_top  = din_top_q;
    assign swap_left    = swap_left_q;
    assign swap_top     = swap_top_q;
    assign shift_right  = shift_right_q;
    assign shift_down   = shift_down_q;
    assign acc_en       = acc_en_q;
    assign acc_rd_en    = acc_rd_q;
    assign addr_acc     = addr_acc_q;
    assign acc_rst      = clr_q;
    assign buffer_rst   = clr_q;
    assign pc_out       = pc_q;
    assign instr_out    = instr_q;
    assign state_out    = state_q;
    assign running      = running_q;
    assign done         = done_q;

endmodule

// File: tb/tb_vpu_sequencer.sv
// Directed bench for vpu_sequencer with behavioural instruction memory and dp_ram models.
module tb_vpu_sequencer;

    logic        clk = 1'b0;
    logic        rst, step, run, halt;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data;
    logic [9:0]  ram_addr_a, ram_addr_b;
    logic [7:0]  ram_dout_a, ram_dout_b;
    logic        load_en_left, load_en_top;
    logic [7:0]  data_in_left, data_in_top;
    logic        swap_left, swap_top, shift_right, shift_down;
    logic        acc_en, acc_rd_en;
    logic [5:0]  addr_acc;
    logic        acc_rst, buffer_rst;
    logic [7:0]  pc_out;
    logic [31:0] instr_out;
    logic [2:0]  state_out;
    logic        running, done;

    logic [31:0] imem [256];
    logic [7:0]  ram  [1024];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int n_sr = 0, n_sd = 0, n_sl = 0, n_st = 0, n_ll = 0, n_lt = 0, n_lc = 0;
    int sr_cyc = 0, sl_cyc = 0, ll_cyc = 0, lt_cyc = 0;
    logic [7:0] ll_data = '0, lt_data = '0;

    int t0, base_a, base_b, base_c, n;

    vpu_sequencer #(
        .DATA_WIDTH(8), .MATRIX_SIZE(8), .ACC_ADDR_WIDTH(6), .DP_ADDR_WIDTH(10),
        .TOP_OFFSET('h40), .INSTR_DEPTH(256), .PC_WIDTH(8), .LOOP_WIDTH(8)
    ) dut (
        .clk(clk), .rst(rst), .step(step), .run(run), .halt(halt),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b),
        .ram_dout_a(ram_dout_a), .ram_dout_b(ram_dout_b),
        .load_en_left(load_en_left), .load_en_top(load_en_top),
        .data_in_left(data_in_left), .data_in_top(data_in_top),
        .swap_left(swap_left), .swap_top(swap_top),
        .shift_right(shift_right), .shift_down(shift_down),
        .acc_en(acc_en), .acc_rd_en(acc_rd_en), .addr_acc(addr_acc),
        .acc_rst(acc_rst), .buffer_rst(buffer_rst),
        .pc_out(pc_out), .instr_out(instr_out), .state_out(state_out),
        .running(running), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc        <= cyc + 1;
        imem_data  <= imem[imem_addr];
        ram_dout_a <= ram[ram_addr_a];
        ram_dout_b <= ram[ram_addr_b];
    end

    always @(negedge clk) begin
        if (shift_right) begin n_sr++; sr_cyc = cyc; end
        if (shift_down)  n_sd++;
        if (swap_left)   begin n_sl++; sl_cyc = cyc; end
        if (swap_top)    n_st++;
        if (load_en_left) begin n_ll++; ll_cyc = cyc; ll_data = data_in_left; end
        if (load_en_top)  begin n_lt++; lt_cyc = cyc; lt_data = data_in_top;  end
        if (state_out == 3'd3) n_lc++;
    end

    wire any_out = |{imem_addr, ram_addr_a, ram_addr_b, load_en_left, load_en_top,
                     data_in_left, data_in_top, swap_left, swap_top, shift_right,
                     shift_down, acc_en, acc_rd_en, addr_acc, acc_rst, buffer_rst,
                     pc_out, instr_out, state_out, running, done};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit cond(input int sel, input int arg);
        logic [2:0] s;
        s = arg[2:0];
        case (sel)
            0:       return state_out == s;
            1:       return acc_en;
            2:       return acc_rd_en;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int sel, input int arg, input int budget, input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (cond(sel, arg)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check(tag, {31'b0, ok}, 32'd1);
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) imem[i] = 32'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1; step = 1'b0; run = 1'b0; halt = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic start_run();
        run = 1'b1;
        t0  = cyc;
        @(negedge clk);
        run = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
        ram[10'h005] = 8'h11;
        ram[10'h045] = 8'h22;
        rst = 1'b1; step = 1'b0; run = 1'b0; halt = 1'b0;

        // 1: single step of SHIFT_RIGHT
        clear_prog();
        imem[0] = 32'h0800_0000;
        do_reset();
        check("rst_state", {29'b0, state_out}, 32'd0);
        check("rst_pc", {24'b0, pc_out}, 32'd0);
        check("rst_outputs", {31'b0, any_out}, 32'd0);
        base_a = n_sr;
        step = 1'b1;
        t0   = cyc;
        @(negedge clk);
        step = 1'b0;
        repeat (6) @(negedge clk);
        check("step_sr_pulses", n_sr - base_a, 32'd1);
        check("step_sr_latency", sr_cyc - t0, 32'd3);
        check("step_pc", {24'b0, pc_out}, 32'd1);
        check("step_state_idle", {29'b0, state_out}, 32'd0);
        check("step_instr", instr_out, 32'h0800_0000);
        check("step_running", {31'b0, running}, 32'd0);

        // 2: dual RAM load with top offset
        clear_prog();
        imem[0] = 32'hC000_0005;
        imem[1] = 32'h0012_0000;
        do_reset();
        base_a = n_ll; base_b = n_lt;
        start_run();
        wait_for(0, 2, 10, "ram_exec_reached");
        check("ram_addr_a", {22'b0, ram_addr_a}, 32'h005);
        check("ram_addr_b", {22'b0, ram_addr_b}, 32'h045);
        wait_for(0, 5, 20, "ram_done_reached");
        @(negedge clk);
        check("ram_left_cnt", n_ll - base_a, 32'd1);
        check("ram_top_cnt", n_lt - base_b, 32'd1);
        check("ram_left_data", {24'b0, ll_data}, 32'h11);
        check("ram_top_data", {24'b0, lt_data}, 32'h22);
        check("ram_same_cycle", ll_cyc - lt_cyc, 32'd0);
        check("ram_latency", ll_cyc - t0, 32'd4);
        check("ram_done", {31'b0, done}, 32'd1);
        check("ram_pc", {24'b0, pc_out}, 32'd2);
        step = 1'b1; run = 1'b1;
        repeat (3) @(negedge clk);
        step = 1'b0; run = 1'b0;
        check("done_sticky_state", {29'b0, state_out}, 32'd5);
        check("done_sticky_pc", {24'b0, pc_out}, 32'd2);

        // 3: immediate top load, no RAM access
        clear_prog();
        imem[0] = 32'h4000_20A7;
        imem[1] = 32'h0012_0000;
        do_reset();
        base_a = n_lt; base_b = n_ll; base_c = n_lc;
        start_run();
        wait_for(0, 5, 20, "imm_done_reached");
        @(negedge clk);
        check("imm_top_cnt", n_lt - base_a, 32'd1);
        check("imm_top_data", {24'b0, lt_data}, 32'hA7);
        check("imm_latency", lt_cyc - t0, 32'd3);
        check("imm_left_cnt", n_ll - base_b, 32'd0);
        check("imm_no_commit", n_lc - base_c, 32'd0);
        check("imm_ram_addr", {12'b0, ram_addr_a, ram_addr_b}, 32'd0);

        // 4: counted loop
        clear_prog();
        imem[0] = 32'h0010_8003;
        imem[1] = 32'h0400_0000;
        imem[2] = 32'h0040_4001;
        imem[3] = 32'h0012_0000;
        do_reset();
        base_a = n_sd;
        start_run();
        wait_for(0, 5, 80, "loop_done_reached");
        @(negedge clk);
        check("loop_sd_pulses", n_sd - base_a, 32'd4);
        check("loop_done", {31'b0, done}, 32'd1);
        check("loop_pc", {24'b0, pc_out}, 32'd4);
        check("loop_running", {31'b0, running}, 32'd0);

        // 5: WAIT 0 vs WAIT 5 latency, then halt during WAIT
        clear_prog();
        imem[0] = 32'h0080_0000;
        imem[1] = 32'h2000_0000;
        imem[2] = 32'h0012_0000;
        do_reset();
        base_a = n_sl;
        start_run();
        wait_for(0, 5, 30, "wait0_done_reached");
        @(negedge clk);
        check("wait0_sl_cnt", n_sl - base_a, 32'd1);
        check("wait0_latency", sl_cyc - t0, 32'd5);
        imem[0] = 32'h0080_0005;
        do_reset();
        base_a = n_sl;
        start_run();
        wait_for(0, 5, 40, "wait5_done_reached");
        @(negedge clk);
        check("wait5_sl_cnt", n_sl - base_a, 32'd1);
        check("wait5_latency", sl_cyc - t0, 32'd10);

        imem[2] = 32'h2000_0000;
        imem[3] = 32'h0012_0000;
        do_reset();
        base_a = n_sl;
        start_run();
        wait_for(0, 4, 10, "halt_wait_reached");
        halt = 1'b1;
        n = 0;
        while (state_out == 3'd4 && n < 20) begin
            n++;
            @(negedge clk);
        end
        halt = 1'b0;
        check("halt_wait_len", n, 32'd5);
        check("halt_state_idle", {29'b0, state_out}, 32'd0);
        check("halt_running", {31'b0, running}, 32'd0);
        check("halt_pc", {24'b0, pc_out}, 32'd1);
        repeat (3) @(negedge clk);
        check("halt_no_swap", n_sl - base_a, 32'd0);
        check("halt_not_done", {31'b0, done}, 32'd0);

        // 6a: asynchronous reset mid-WAIT
        clear_prog();
        imem[0] = 32'h0080_0005;
        imem[1] = 32'h0800_0000;
        imem[2] = 32'h0012_0000;
        do_reset();
        start_run();
        wait_for(0, 4, 10, "arst_wait_reached");
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_wait_state", {29'b0, state_out}, 32'd0);
        check("arst_wait_pc", {24'b0, pc_out}, 32'd0);
        check("arst_wait_outputs", {31'b0, any_out}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        base_a = n_sr;
        start_run();
        wait_for(0, 5, 40, "arst_wait_rerun_done");
        @(negedge clk);
        check("arst_wait_rerun_sr", n_sr - base_a, 32'd1);
        check("arst_wait_rerun_pc", {24'b0, pc_out}, 32'd3);

        // 6b: asynchronous reset mid-LOAD_COMMIT
        clear_prog();
        imem[0] = 32'h1000_0000;
        imem[1] = 32'hC000_0005;
        imem[2] = 32'h0012_0000;
        do_reset();
        start_run();
        wait_for(0, 3, 20, "arst_lc_reached");
        #2 rst = 1'b1;
        #1;
        check("arst_lc_state", {29'b0, state_out}, 32'd0);
        check("arst_lc_pc", {24'b0, pc_out}, 32'd0);
        check("arst_lc_outputs", {31'b0, any_out}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        base_a = n_st; base_b = n_ll;
        start_run();
        wait_for(0, 5, 40, "arst_lc_rerun_done");
        @(negedge clk);
        check("arst_lc_rerun_st", n_st - base_a, 32'd1);
        check("arst_lc_rerun_ll", n_ll - base_b, 32'd1);
        check("arst_lc_rerun_data", {24'b0, ll_data}, 32'h11);
        check("arst_lc_rerun_pc", {24'b0, pc_out}, 32'd3);

        // 7: LOAD_ACC + CLR, absolute JUMP, WRITE_ACC_OUT + HALT
        clear_prog();
        imem[0] = 32'h0220_002B;
        imem[1] = 32'h0040_0005;
        imem[5] = 32'h0102_0013;
        do_reset();
        start_run();
        wait_for(1, 0, 10, "acc_en_reached");
        check("acc_rst", {31'b0, acc_rst}, 32'd1);
        check("buffer_rst", {31'b0, buffer_rst}, 32'd1);
        check("acc_addr_wr", {26'b0, addr_acc}, 32'h2B);
        check("acc_rd_idle", {31'b0, acc_rd_en}, 32'd0);
        wait_for(2, 0, 20, "acc_rd_reached");
        check("acc_addr_rd", {26'b0, addr_acc}, 32'h13);
        check("acc_en_idle", {31'b0, acc_en}, 32'd0);
        wait_for(0, 5, 20, "jump_done_reached");
        check("jump_pc", {24'b0, pc_out}, 32'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vpu_sequencer.md
Name: vpu_sequencer

Overview:
- Parametrised instruction sequencer that replaces the fixed single-step controller.
- Fetches 32-bit instructions from the UART-loaded instruction memory through a synchronous read port.
- Decodes them into one-cycle control strobes for the systolic module and read addresses for the dual-port RAM.
- Adds free-running run mode, halt, WAIT_CYCLES, absolute/looped JUMP and CLR; instantiated by the top-level controller alongside the systolic module, dp_ram and loader.

Parameters:
DATA_WIDTH, 8, systolic operand width (must be ≤ 13)
MATRIX_SIZE, 8, systolic array dimension
ACC_ADDR_WIDTH, $clog2(MATRIX_SIZE*MATRIX_SIZE), accumulator address width
DP_ADDR_WIDTH, 10, dual-port RAM address width
TOP_OFFSET, 'h40, port-B address offset for dual LOAD_LEFT+LOAD_TOP
INSTR_DEPTH, 256, instruction memory depth
PC_WIDTH, $clog2(INSTR_DEPTH), program counter width
LOOP_WIDTH, 8, loop counter width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
step  in  1  execute one instruction (sampled in IDLE)
run  in  1  start free-running execution (sampled in IDLE)
halt  in  1  stop run mode at the next instruction boundary
imem_addr  out  PC_WIDTH  instruction read address (= pc)
imem_data  in  32  instruction word, valid 1 cycle after imem_addr is stable
ram_addr_a / ram_addr_b  out  DP_ADDR_WIDTH  RAM read addresses
ram_dout_a / ram_dout_b  in  DATA_WIDTH  RAM data, 1-cycle read latency
load_en_left / load_en_top  out  1  operand load strobes
data_in_left / data_in_top  out  DATA_WIDTH  operand data
swap_left / swap_top / shift_right / shift_down  out  1  array strobes
acc_en / acc_rd_en  out  1  LOAD_ACC / WRITE_ACC_OUT strobes
addr_acc  out  ACC_ADDR_WIDTH  accumulator address
acc_rst / buffer_rst  out  1  CLR strobes
pc_out  out  PC_WIDTH  debug pc
instr_out  out  32  last executed instruction
state_out  out  3  FSM state encoding
running / done  out  1  status flags

Behaviour:
Instruction fields:
- Bits 31..20: LOAD_LEFT, LOAD_TOP, SWAP_LEFT, SWAP_TOP, SHIFT_RIGHT, SHIFT_DOWN, LOAD_ACC, WRITE_ACC_OUT, WAIT_CYCLES, JUMP, CLR, NOP.
- FLAGS = 17:13: FLAGS[0]=IMM, FLAGS[1]=LOOP, FLAGS[2]=SET_LOOP, FLAGS[4]=HALT.
- ADDR = 12:0.

Reset:
- All outputs, pc, loop_cnt, wait_cnt, instr_out and running are 0; done is 0; state is IDLE.
- Reset is effective immediately at any point, including mid-WAIT or mid-LOAD_COMMIT.

States: IDLE=0, FETCH=1, EXEC=2, LOAD_COMMIT=3, WAIT=4, DONE=5.
- IDLE: run → running<=1, go to FETCH. Else step → running<=0, go to FETCH. run wins if both are high.
- FETCH: one-cycle wait for imem_data.
- EXEC: latch imem_data into instr_out and decode. Strobes are registered, so they are high exactly one cycle, in the cycle after EXEC.
  - SWAP_LEFT/TOP, SHIFT_RIGHT/DOWN, CLR (acc_rst and buffer_rst): pulse the matching outputs.
  - LOAD_ACC/WRITE_ACC_OUT: pulse acc_en/acc_rd_en with addr_acc = ADDR[ACC_ADDR_WIDTH-1:0].
  - LOAD with IMM: data_in_* = ADDR[DATA_WIDTH-1:0] and load_en pulse for each selected side.
  - LOAD without IMM, LEFT only: ram_addr_a = ADDR.
  - LOAD without IMM, TOP only: ram_addr_b = ADDR.
  - LOAD without IMM, both: ram_addr_a = ADDR and ram_addr_b = ADDR + TOP_OFFSET, wrapping mod 2^DP_ADDR_WIDTH. Next state is LOAD_COMMIT.
  - SET_LOOP: loop_cnt <= ADDR[LOOP_WIDTH-1:0].
  - JUMP without LOOP: pc <= ADDR[PC_WIDTH-1:0].
  - JUMP with LOOP: if loop_cnt ≠ 0, loop_cnt-1 and jump; else fall through.
  - Otherwise pc <= pc+1, wrapping to 0 after INSTR_DEPTH-1.
- LOAD_COMMIT: data_in_* <= ram_dout_*, and load_en pulses for the sides requested.
- WAIT: entered from EXEC/LOAD_COMMIT when WAIT_CYCLES and ADDR ≠ 0. Holds exactly ADDR cycles (wait_cnt counts down to 1). WAIT_CYCLES with ADDR=0 does not wait.
- Instruction boundary, at the end of EXEC/LOAD_COMMIT/WAIT:
  - HALT flag → DONE (done=1, running=0).
  - Else running and halt=0 → FETCH.
  - Else IDLE with running=0.
  - halt never aborts a WAIT or LOAD_COMMIT already in progress.
- DONE: sticky until rst; step and run are ignored.
- Precedence: strobes, loads, loop and pc update all take effect in the same EXEC. WAIT occurs after LOAD_COMMIT. HALT is evaluated last.
- Throughput: 2 cycles per plain instruction (FETCH+EXEC); +1 for a RAM load; +N for WAIT N.

Test Plan:
1. rst; imem[0]=SHIFT_RIGHT (0x08000000); pulse step → shift_right high for 1 cycle, 2 cycles after step; pc_out=1; state returns to IDLE=0.
2. imem[0]=LOAD_LEFT|LOAD_TOP with ADDR=0x005 (0xC0000005); run → ram_addr_a=0x005, ram_addr_b=0x045; with ram_dout_a=0x11 and ram_dout_b=0x22, load_en_left=load_en_top=1 with data 0x11/0x22 in the same cycle.
3. Immediate: LOAD_TOP|IMM, ADDR=0x0A7 (0x400020A7) → data_in_top=0xA7 with load_en_top, and no RAM access.
4. Loop: imem[0]=NOP+SET_LOOP ADDR=3; imem[1]=SHIFT_DOWN; imem[2]=JUMP+LOOP ADDR=1; imem[3]=NOP+HALT; run → exactly 4 shift_down pulses, then done=1, pc_out=4, and running=0.
5. WAIT ADDR=5 followed by SWAP_LEFT → swap_left pulse appears exactly 5 cycles later than with WAIT ADDR=0; halt asserted mid-WAIT → WAIT completes, then IDLE.
6. Assert rst asynchronously mid-WAIT and mid-LOAD_COMMIT → all outputs 0 immediately, state 0, pc 0; a run after release re-executes from pc 0.
